// File: rtl/unsigned_radix2_divider.sv
// Iterative radix-2 restoring divider for unsigned operands.
// One quotient bit per cycle; a zero divisor completes in a single cycle with RISC-V results.
module unsigned_radix2_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  divisor_is_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_RUN    = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [0:0]    r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_work_q;
  logic [W-1:0]  r_work_r;
  logic [W-1:0]  r_div;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_done;
  logic          r_div_zero;

  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_rem_next;
  logic [W-1:0]  w_q_next;

  // One restoring step; the shifted partial remainder is W+1 bits so large divisors cannot overflow.
  always_comb begin
    w_shift = {r_work_r, r_work_q[W-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_diff  = w_shift[W-1:0] - r_div;
    if (w_ge) begin
      w_rem_next = w_diff;
      w_q_next   = {r_work_q[W-2:0], 1'b1};
    end else begin
      w_rem_next = w_shift[W-1:0];
      w_q_next   = {r_work_q[W-2:0], 1'b0};
    end
  end

  // Control FSM, working registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= CNT_ZERO;
      r_work_q    <= {W{1'b0}};
      r_work_r    <= {W{1'b0}};
      r_div       <= {W{1'b0}};
      r_quotient  <= {W{1'b0}};
      r_remainder <= {W{1'b0}};
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // A new start wins over any operation in flight.
        if (divisor == {W{1'b0}}) begin
          r_state     <= S_IDLE;
          r_count     <= CNT_ZERO;
          r_quotient  <= {W{1'b1}};
          r_remainder <= dividend;
          r_div_zero  <= 1'b1;
          r_done      <= 1'b1;
        end else begin
          r_state  <= S_RUN;
          r_count  <= CNT_LAST;
          r_work_q <= dividend;
          r_work_r <= {W{1'b0}};
          r_div    <= divisor;
        end
      end else if (r_state == S_RUN) begin
        r_work_q <= w_q_next;
        r_work_r <= w_rem_next;
        if (r_count == CNT_ZERO) begin
          r_state     <= S_IDLE;
          r_quotient  <= w_q_next;
          r_remainder <= w_rem_next;
          r_div_zero  <= 1'b0;
          r_done      <= 1'b1;
        end else begin
          r_count <= r_count - CNT_ONE;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign quotient        = r_quotient;
  assign remainder       = r_remainder;
  assign done            = r_done;
  assign divisor_is_zero = r_div_zero;

endmodule

// File: tb/tb_unsigned_radix2_divider.sv
// Directed-vector bench for unsigned_radix2_divider (W=32): results, latency,
// abort, back-to-back, mid-op reset and a small set of model-checked operands.
module tb_unsigned_radix2_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         divisor_is_zero;

  int n_vec = 0;
  int n_err = 0;

  unsigned_radix2_divider #(.DATA_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .quotient        (quotient),
    .remainder       (remainder),
    .done            (done),
    .divisor_is_zero (divisor_is_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one op, scramble operands while it runs, then check latency, results and pulse width.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int elat);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    do begin
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      lat++;
    end while (!done && lat < 100);
    check_val({tag, "_lat"}, 32'(lat), 32'(elat));
    check_val({tag, "_q"}, quotient, eq);
    check_val({tag, "_r"}, remainder, er);
    check_val({tag, "_dz"}, 32'(divisor_is_zero), 32'(edz));
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dcount, first_at, second_at, done_at;
    bit held_ok;
    logic [W-1:0] a, b, eq, er;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_q", quotient, 32'd0);
    check_val("rst_r", remainder, 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_dz", 32'(divisor_is_zero), 32'd0);
    rst_n = 1'b1;

    run_op("d100_7",    32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    run_op("d1234_0",   32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1);
    run_op("dmax_1",    32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33);
    run_op("dmax_msb",  32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 33);
    run_op("d5_9",      32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33);
    run_op("d0_3",      32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 33);
    run_op("dmsb_max",  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33);
    run_op("dmax_max",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33);
    run_op("d12345_123",32'd12345,      32'd123,        32'd100,        32'd45,         1'b0, 33);

    // Abort: 100/7 restarted as 50/5 ten cycles later; prior 100/45 must hold until the one done.
    dcount = 0; done_at = 0; held_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
      if (done) begin
        dcount++;
        if (dcount == 1) done_at = c;
      end else if (dcount == 0 && (quotient !== 32'd100 || remainder !== 32'd45)) begin
        held_ok = 1'b0;
      end
    end
    check_val("abort_ndone", 32'(dcount), 32'd1);
    check_val("abort_at", 32'(done_at), 32'd43);
    check_val("abort_held", 32'(held_ok), 32'd1);
    check_val("abort_q", quotient, 32'd10);
    check_val("abort_r", remainder, 32'd0);

    // Reset five cycles into 100/7: outputs clear at once, no done afterwards.
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mrst_q", quotient, 32'd0);
    check_val("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_val("mrst_nodone", 32'(dcount), 32'd0);

    // Back-to-back: second start lands in the first done cycle.
    dcount = 0; first_at = 0; second_at = 0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dcount++;
        if (dcount == 1) begin
          first_at = c;
          check_val("b2b_q1", quotient, 32'd14);
          check_val("b2b_r1", remainder, 32'd2);
          start = 1'b1; dividend = 32'hFFFF_FFFF; divisor = 32'h0000_0010;
        end else begin
          second_at = c;
        end
      end
    end
    check_val("b2b_ndone", 32'(dcount), 32'd2);
    check_val("b2b_first", 32'(first_at), 32'd33);
    check_val("b2b_gap", 32'(second_at - first_at), 32'd33);
    check_val("b2b_q2", quotient, 32'h0FFF_FFFF);
    check_val("b2b_r2", remainder, 32'h0000_000F);

    // Model-checked operands with zero/max/small corners mixed in.
    for (int i = 0; i < 120; i++) begin
      case (i % 5)
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'($urandom_range(0, 1000));
        default: a = $urandom;
      endcase
      case (i % 7)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 50));
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0) begin
        eq = 32'hFFFF_FFFF; er = a;
        run_op("rnd", a, b, eq, er, 1'b1, 1);
      end else begin
        eq = a / b; er = a % b;
        run_op("rnd", a, b, eq, er, 1'b0, 33);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
